acorn128_ctrl: RTL
==================

Name: acorn128_ctrl

Overview:
- Phase sequencer for the ACORN-128 single-step state-update datapath: generates per-step ca, cb, message bit and step strobe for initialization, associated-data (AD) absorption, AD padding, message encryption, message padding and finalization.
- Consumes the datapath keystream bit to produce ciphertext bits and the 128-bit tag.
- Sits between the host bit-stream interfaces and the state-update/keystream datapath.

Parameters:
- INIT_STEPS, 1792, initialization step count.
- PAD_STEPS, 256, padding steps after AD and after message.
- FIN_STEPS, 768, finalization step count.
- TAG_BITS, 128, tag length; the last TAG_BITS finalization keystream bits.
- CNT_W, 11, step counter width; must satisfy 2^CNT_W > INIT_STEPS.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin operation; sampled only in IDLE
- key  in  128  key; latched on accepted start
- iv  in  128  IV; latched on accepted start
- ad_empty  in  1  no AD; sampled with start
- msg_empty  in  1  no message; sampled with start
- dec  in  1  decrypt mode; sampled with start (see Optional Feature)
- ad_valid / ad_ready / ad_bit / ad_last  in/out/in/in  1 each  AD bit stream
- msg_valid / msg_ready / msg_bit / msg_last  in/out/in/in  1 each  message bit stream
- ks_in  in  1  datapath keystream bit for the current step
- step_en  out  1  advance datapath one step this cycle
- state_clr  out  1  clear datapath state (one-cycle pulse)
- ca_out, cb_out, mbit_out  out  1 each  datapath control/message inputs
- out_valid / out_bit  out  1 each  ciphertext (or plaintext) bit; no backpressure
- busy  out  1  high in any state except IDLE and DONE
- tag  out  TAG_BITS  computed tag
- tag_valid  out  1  tag valid; held until next accepted start or reset

Behaviour:
- Reset: state IDLE, counter 0, all outputs 0, tag cleared.
- FSM states: IDLE, INIT, AD, AD_PAD, MSG, MSG_PAD, FIN, DONE.
- IDLE: start=1 latches key, iv, ad_empty, msg_empty and dec; pulses state_clr for that cycle; clears tag_valid; moves to INIT with counter 0.
- INIT: step_en=1 every cycle; ca=cb=1.
  - mbit: counter i<128 gives key[i]; i<256 gives iv[i-128]; otherwise key[i mod 128], XOR 1 when i=256.
  - At i=INIT_STEPS-1, go to AD_PAD if ad_empty, else AD.
- AD: ad_ready=1; step_en=ad_valid; ca=cb=1; mbit=ad_bit.
  - A step with ad_last=1 moves to AD_PAD.
- AD_PAD: PAD_STEPS steps; cb=1; ca=1 for pad index <128, else 0; mbit=1 at index 0, else 0.
  - Then go to MSG_PAD if msg_empty, else MSG.
- MSG: msg_ready=1; step_en=msg_valid; ca=1, cb=0; mbit=msg_bit.
  - Same cycle: out_valid=msg_valid, out_bit=msg_bit^ks_in.
  - A step with msg_last=1 moves to MSG_PAD.
- MSG_PAD: same as AD_PAD but cb=0; then FIN.
- FIN: FIN_STEPS steps; ca=cb=1; mbit=0.
  - Steps with index j >= FIN_STEPS-TAG_BITS write ks_in into tag[j-(FIN_STEPS-TAG_BITS)]; tag bit 0 is the earliest.
  - After the last step go to DONE.
- DONE: tag_valid=1; one cycle later return to IDLE, tag_valid held.
- Latency: with empty AD and empty message, step_en is high for exactly INIT_STEPS+2*PAD_STEPS+FIN_STEPS = 3072 consecutive cycles; tag_valid rises 2 cycles after the last step.
- ready signals are 0 outside their own state; the stream is not consumed when valid=0, and ca/cb/mbit are don't-care with step_en=0.
- start while busy: ignored. ad_valid/msg_valid outside their state: ignored.
- rst mid-operation: immediate IDLE, tag and tag_valid cleared.
- Counter resets to 0 on every state transition; no wrap occurs within a state.

Optional Feature:
- Macro ACORN_DECRYPT_EN.
- Defined, with latched dec=1: in MSG the recovered plaintext is p=msg_bit^ks_in. mbit_out=p and out_bit=p, so the absorbed bit is the plaintext.
- Undefined: dec is ignored and the block always encrypts.

Test Plan:
- Reset mid-INIT (counter 500) -> next cycle IDLE; step_en=0, busy=0, tag_valid=0.
- key=0, iv=0, empty AD/message -> step_en high 3072 cycles; mbit_out=1 only at INIT step 256 and pad index 0 of both pads; tag_valid asserts.
- ad_empty=0, 3-bit AD 1,0,1 with ad_valid gaps of 2 cycles -> exactly 3 AD steps with mbit 1,0,1; step_en low in gaps; AD_PAD ca pattern 128 ones then 128 zeros.
- 8-bit message 0xA5 with ks_in forced 0xFF -> out_bit sequence equals msg_bit^1 for all 8 bits; MSG cb_out=0, ca_out=1.
- FIN with ks_in driven from an LFSR model -> tag equals the model's last 128 bits; tag[0] is the ks at FIN step 640.
- ACORN_DECRYPT_EN defined, dec=1, encrypt-then-decrypt round trip -> recovered plaintext matches the original and the tags are equal.

Source files
------------

// File: rtl/acorn128_ctrl.sv
// acorn128_ctrl: ACORN-128 phase sequencer (init, AD, pads, message, fin).
// Define ACORN_DECRYPT_EN to honour the dec input (decrypt mode).
module acorn128_ctrl #(
   parameter int INIT_STEPS = 1792,
   parameter int PAD_STEPS  = 256,
   parameter int FIN_STEPS  = 768,
   parameter int TAG_BITS   = 128,
   parameter int CNT_W      = 11
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [127:0]        key,
   input  logic [127:0]        iv,
   input  logic                ad_empty,
   input  logic                msg_empty,
   input  logic                dec,
   input  logic                ad_valid,
   output logic                ad_ready,
   input  logic                ad_bit,
   input  logic                ad_last,
   input  logic                msg_valid,
   output logic                msg_ready,
   input  logic                msg_bit,
   input  logic                msg_last,
   input  logic                ks_in,
   output logic                step_en,
   output logic                state_clr,
   output logic                ca_out,
   output logic                cb_out,
   output logic                mbit_out,
   output logic                out_valid,
   output logic                out_bit,
   output logic                busy,
   output logic [TAG_BITS-1:0] tag,
   output logic                tag_valid
);

   localparam int TI_W = $clog2(TAG_BITS);

   localparam logic [CNT_W-1:0] INIT_LAST =
      CNT_W'(INIT_STEPS - 1);
   localparam logic [CNT_W-1:0] PAD_LAST =
      CNT_W'(PAD_STEPS - 1);
   localparam logic [CNT_W-1:0] FIN_LAST =
      CNT_W'(FIN_STEPS - 1);
   localparam logic [CNT_W-1:0] TAG_FIRST =
      CNT_W'(FIN_STEPS - TAG_BITS);
   localparam logic [CNT_W-1:0] C128 = CNT_W'(128);
   localparam logic [CNT_W-1:0] C256 = CNT_W'(256);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_AD,
      S_AD_PAD,
      S_MSG,
      S_MSG_PAD,
      S_FIN,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [127:0]        key_q, key_d;
   logic [127:0]        iv_q, iv_d;
   logic                ad_empty_q, ad_empty_d;
   logic                msg_empty_q, msg_empty_d;
   logic [TAG_BITS-1:0] tag_q, tag_d;
   logic                tag_valid_q, tag_valid_d;
   logic                init_mbit;
   logic                msg_p;

`ifdef ACORN_DECRYPT_EN
   logic dec_q, dec_d;
`else
   logic unused_dec;
   assign unused_dec = dec;
`endif

   assign msg_p     = msg_bit ^ ks_in;
   assign tag       = tag_q;
   assign tag_valid = tag_valid_q;

   // Init-phase message bit: key, then IV, then key again with a 1 at 256.
   always_comb begin
      init_mbit = 1'b0;
      if (cnt_q < C128) begin
         init_mbit = key_q[cnt_q[6:0]];
      end else if (cnt_q < C256) begin
         init_mbit = iv_q[cnt_q[6:0]];
      end else begin
         init_mbit = key_q[cnt_q[6:0]] ^ (cnt_q == C256);
      end
   end

   // Next-state, counter, latches and per-step datapath controls.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      key_d       = key_q;
      iv_d        = iv_q;
      ad_empty_d  = ad_empty_q;
      msg_empty_d = msg_empty_q;
      tag_d       = tag_q;
      tag_valid_d = tag_valid_q;
`ifdef ACORN_DECRYPT_EN
      dec_d       = dec_q;
`endif
      step_en     = 1'b0;
      state_clr   = 1'b0;
      ca_out      = 1'b0;
      cb_out      = 1'b0;
      mbit_out    = 1'b0;
      ad_ready    = 1'b0;
      msg_ready   = 1'b0;
      out_valid   = 1'b0;
      out_bit     = 1'b0;
      busy        = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_clr   = 1'b1;
               key_d       = key;
               iv_d        = iv;
               ad_empty_d  = ad_empty;
               msg_empty_d = msg_empty;
`ifdef ACORN_DECRYPT_EN
               dec_d       = dec;
`endif
               tag_valid_d = 1'b0;
               cnt_d       = '0;
               state_d     = S_INIT;
            end
         end
         S_INIT: begin
            step_en  = 1'b1;
            ca_out   = 1'b1;
            cb_out   = 1'b1;
            mbit_out = init_mbit;
            if (cnt_q == INIT_LAST) begin
               cnt_d   = '0;
               state_d = ad_empty_q ? S_AD_PAD : S_AD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_AD: begin
            ad_ready = 1'b1;
            step_en  = ad_valid;
            ca_out   = 1'b1;
            cb_out   = 1'b1;
            mbit_out = ad_bit;
            cnt_d    = '0;
            if (ad_valid && ad_last) begin
               state_d = S_AD_PAD;
            end
         end
         S_AD_PAD: begin
            step_en  = 1'b1;
            ca_out   = (cnt_q < C128);
            cb_out   = 1'b1;
            mbit_out = (cnt_q == '0);
            if (cnt_q == PAD_LAST) begin
               cnt_d   = '0;
               state_d = msg_empty_q ? S_MSG_PAD : S_MSG;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_MSG: begin
            msg_ready = 1'b1;
            step_en   = msg_valid;
            ca_out    = 1'b1;
            cb_out    = 1'b0;
            mbit_out  = msg_bit;
            out_valid = msg_valid;
            out_bit   = msg_p;
`ifdef ACORN_DECRYPT_EN
            if (dec_q) begin
               mbit_out = msg_p;
            end
`endif
            cnt_d = '0;
            if (msg_valid && msg_last) begin
               state_d = S_MSG_PAD;
            end
         end
         S_MSG_PAD: begin
            step_en  = 1'b1;
            ca_out   = (cnt_q < C128);
            cb_out   = 1'b0;
            mbit_out = (cnt_q == '0);
            if (cnt_q == PAD_LAST) begin
               cnt_d   = '0;
               state_d = S_FIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_FIN: begin
            step_en = 1'b1;
            ca_out  = 1'b1;
            cb_out  = 1'b1;
            if (cnt_q >= TAG_FIRST) begin
               tag_d[TI_W'(cnt_q - TAG_FIRST)] = ks_in;
            end
            if (cnt_q == FIN_LAST) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            busy        = 1'b0;
            tag_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = S_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State register; reset abandons any operation and clears the tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         key_q       <= '0;
         iv_q        <= '0;
         ad_empty_q  <= 1'b0;
         msg_empty_q <= 1'b0;
         tag_q       <= '0;
         tag_valid_q <= 1'b0;
`ifdef ACORN_DECRYPT_EN
         dec_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         key_q       <= key_d;
         iv_q        <= iv_d;
         ad_empty_q  <= ad_empty_d;
         msg_empty_q <= msg_empty_d;
         tag_q       <= tag_d;
         tag_valid_q <= tag_valid_d;
`ifdef ACORN_DECRYPT_EN
         dec_q       <= dec_d;
`endif
      end
   end

endmodule
